// File: rtl/onewire_pkg.sv
// Shared 1-Wire definitions: slave sequencer states and default protocol timings in
// microseconds. The reset checker uses the same timings.
package onewire_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_REL,
    DELAY,
    DRIVE,
    RECOVER
  } ow_state_e;

  localparam int unsigned OW_RESET_US    = 480;
  localparam int unsigned OW_DELAY_US    = 30;
  localparam int unsigned OW_PRESENCE_US = 120;
  localparam int unsigned OW_RECOVER_US  = 240;
  localparam int unsigned OW_RELEASE_US  = 960;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ow_cycle_timer.sv
// Loadable down-counter. It saturates at zero and never wraps. A load takes priority
// over counting.
module ow_cycle_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = load_val;
    else if (count_q != '0)
      count_d = count_q - W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only; combinational next-state
  // logic stays in always_comb with blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/onewire_presence_gen.sv
// 1-Wire presence-pulse generator that answers the reset checker's reset_found edge.
// The optional WAIT_REL timeout is enabled by defining ONEWIRE_REL_TIMEOUT_EN.
module onewire_presence_gen
  import onewire_pkg::*;
#(
  parameter int unsigned DELAY_CYC       = OW_DELAY_US,
  parameter int unsigned PULSE_CYC       = OW_PRESENCE_US,
  parameter int unsigned RECOVER_MAX_CYC = OW_RECOVER_US,
  parameter int unsigned RELEASE_MAX_CYC = OW_RELEASE_US
) (
  input  logic clk,
  input  logic rst,
  input  logic reset_found,
  input  logic bus_in,
  output logic bus_drive_low,
  output logic busy,
  output logic presence_done,
  output logic bus_fault
);

  localparam int unsigned CNT_W =
    $clog2(max4(DELAY_CYC, PULSE_CYC, RECOVER_MAX_CYC, RELEASE_MAX_CYC)) + 1;

  ow_state_e  state_q, state_d;
  logic       found_prev_q;
  logic       drive_q, drive_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       fault_q, fault_d;
  logic       tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic       tmr_zero;
  logic       trigger;

  assign trigger = reset_found && !found_prev_q;

  ow_cycle_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    done_d   = 1'b0;
    fault_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = WAIT_REL;
`ifdef ONEWIRE_REL_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(RELEASE_MAX_CYC - 1);
`endif
        end
      end
      WAIT_REL: begin
        if (bus_in) begin
          state_d  = DELAY;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(DELAY_CYC - 1);
        end
`ifdef ONEWIRE_REL_TIMEOUT_EN
        else if (tmr_zero) begin
          fault_d = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      DELAY: begin
        // A low bus here means the master has started a new reset, so drop the sequence quietly.
        if (!bus_in) begin
          state_d = IDLE;
        end else if (tmr_zero) begin
          state_d  = DRIVE;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(PULSE_CYC - 1);
        end
      end
      DRIVE: begin
        if (tmr_zero) begin
          state_d  = RECOVER;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(RECOVER_MAX_CYC - 1);
        end
      end
      RECOVER: begin
        if (bus_in) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (tmr_zero) begin
          fault_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The outputs are registered from next-state, so each output changes on the same edge as the state.
  assign drive_d = (state_d == DRIVE);
  assign busy_d  = (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      found_prev_q <= 1'b0;
      drive_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      found_prev_q <= reset_found;
      drive_q      <= drive_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fault_q      <= fault_d;
    end
  end

  assign bus_drive_low = drive_q;
  assign busy          = busy_q;
  assign presence_done = done_q;
  assign bus_fault     = fault_q;

endmodule
